dcm_prog_ctrl: RTL and testbench
================================

# dcm_prog_ctrl

Sequencing controller for the clock manager (`dcm`) that owns its `update`/`prog_in` programming port. The block accepts frequency-select commands (absolute set, step slower, step faster) from user logic and issues exactly one `update` pulse per change. It then waits until the manager's `prog_out` reports the new selection, and exposes the confirmed selection, busy/done status and a timeout error. It sits between the front-panel/control logic and the `dcm`, and is the only driver of the `dcm` programming inputs.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: maximum `clk` cycles to wait for `dcm_prog_out` to match the target (10 ms at 100 MHz).
- `RESET_PROG`, default 3'd0: selection programmed automatically after reset (0 = 10 Hz).
- `clk` in 1: 100 MHz reference clock, the same clock that drives the `dcm`.
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_op` in 2: 00 SET, 01 SLOWER (+1), 10 FASTER (−1), 11 NOP.
- `cmd_sel` in 3: target selection for SET. 0 = 10 Hz, each step halves, 7 = 78.125 mHz.
- `cmd_ready` out 1: the command slot can accept a command.
- `dcm_update` out 1: one-cycle programming strobe to the `dcm`.
- `dcm_prog_in` out 3: selection driven to the `dcm`.
- `dcm_prog_out` in 3: selection currently reported by the `dcm`.
- `cur_prog` out 3: last confirmed selection.
- `busy` out 1: a programming sequence is in flight.
- `done` out 1: one-cycle pulse when the target is confirmed.
- `timeout` out 1: sticky error. Set on a failed sequence; cleared when the next command is accepted.

## Operation
- Command accepted on a rising edge with `cmd_valid && cmd_ready`. NOP is accepted and discarded, with no side effects.
- One-deep pending slot. `cmd_ready` = slot empty. A command accepted while `busy` is held in the slot and started after the current sequence ends.
- Target resolution happens when the command leaves the slot or starts directly:
  - SET uses `cmd_sel`.
  - SLOWER uses base+1, saturating at 7.
  - FASTER uses base−1, saturating at 0.
  - Base = target of the in-flight sequence if one exists, else `cur_prog`.
- If the resolved target equals `cur_prog` and nothing is in flight, there is no `dcm_update`. The FSM goes straight to DONE, and `done` pulses.
- FSM states and transitions:
  - INIT: entered out of reset; target = `RESET_PROG`; next state ISSUE.
  - IDLE: waits for a command; goes to ISSUE, or to DONE when the target already equals `cur_prog`.
  - ISSUE: `dcm_update`=1 for this cycle only; `dcm_prog_in` loaded with the target; timeout counter cleared; next state WAIT.
  - WAIT: compares `dcm_prog_out` with the target every cycle.
    - Match: go to DONE.
    - Counter reaches `TIMEOUT_CYCLES`: set `timeout`, load `cur_prog` from `dcm_prog_out`, go to IDLE.
  - DONE: `done`=1; `cur_prog` loaded with the target. Next state is ISSUE if the slot holds a command (pop it), else IDLE.
- `busy` = state ∉ {IDLE}.
- `dcm_prog_in` holds its value between ISSUE states and is never changed outside ISSUE.

## Timing
- Reset values:
  - state = INIT
  - `dcm_update` 0
  - `dcm_prog_in` = `RESET_PROG`
  - `cur_prog` = `RESET_PROG`
  - `busy` 1
  - `done` 0
  - `timeout` 0
  - `cmd_ready` 1
  - slot empty, counter 0
- Command accepted at edge k from IDLE: `dcm_update` high in cycle k+1, WAIT from k+2.
- A match first seen in WAIT cycle m gives `done` and the `cur_prog` update in cycle m+1. `busy` falls in cycle m+2 if the slot is empty.
- Slot pop from DONE: the next ISSUE follows DONE directly, so there are no IDLE cycles between back-to-back sequences.
- Accept and pop in the same cycle as DONE: the pop wins and the new command fills the slot. `cmd_ready` is registered, so it is low for at least that cycle.
- Timeout counter width = $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- Reset asserted mid-sequence: asynchronous return to INIT. `dcm_update` drops immediately and the slot is flushed.
- A `dcm_prog_out` match that coincides with the terminal count counts as a match (DONE), not a timeout.

## Structure
- `dcm_pkg`:
  - `cmd_op_t` encodings (SET, SLOWER, FASTER, NOP)
  - `state_t` enum (INIT, IDLE, ISSUE, WAIT, DONE)
  - `PROG_W`=3, `PROG_MIN`=0, `PROG_MAX`=7
- Sub-module `dcm_timeout_cnt`: saturating counter with clear/enable inputs and a terminal-count flag, parameterised by `TIMEOUT_CYCLES`.
- Everything else is a single FSM plus the slot register in `dcm_prog_ctrl`.

## Test plan
- Reset release with `dcm_prog_out` following `dcm_prog_in` after 3 cycles -> one `dcm_update` with `dcm_prog_in`=0, then `done`; `cur_prog`=0, `busy`=0.
- SET 5, then SLOWER while busy -> second target = 6 (based on the in-flight 5); two updates, back-to-back with no IDLE gap; final `cur_prog`=6.
- `cur_prog`=7, SLOWER -> target saturates at 7; no `dcm_update`; `done` pulses 1 cycle after acceptance. `cur_prog`=0, FASTER -> same behaviour at 0.
- `TIMEOUT_CYCLES`=16, `dcm_prog_out` stuck at 2, SET 4 -> `timeout`=1 after 16 WAIT cycles, `cur_prog`=2. Next accepted SET clears `timeout`.
- Slot full (busy + one pending) -> `cmd_ready`=0, and a third `cmd_valid` is not accepted until DONE pops the slot.
- `rst` asserted during WAIT -> outputs return to reset values asynchronously; slot flushed; INIT reprograms `RESET_PROG`.

Source files
------------

// File: rtl/dcm_pkg.sv
// Shared types and constants for the clock-manager programming controller.
package dcm_pkg;

   localparam int PROG_W = 3;
   localparam logic [PROG_W-1:0] PROG_MIN = 3'd0;
   localparam logic [PROG_W-1:0] PROG_MAX = 3'd7;

   typedef enum logic [1:0] {
      OP_SET    = 2'b00,
      OP_SLOWER = 2'b01,
      OP_FASTER = 2'b10,
      OP_NOP    = 2'b11
   } cmd_op_t;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   // Selection a command asks for, relative to `base` for the step operations.
   // Steps saturate at the ends of the selection range.
   function automatic logic [PROG_W-1:0] resolve_target(
      input cmd_op_t           op,
      input logic [PROG_W-1:0] sel,
      input logic [PROG_W-1:0] base
   );
      logic [PROG_W-1:0] t;
      t = base;
      case (op)
         OP_SET:    t = sel;
         OP_SLOWER: t = (base == PROG_MAX) ? base : base + 1'b1;
         OP_FASTER: t = (base == PROG_MIN) ? base : base - 1'b1;
         default:   t = base;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/dcm_timeout_cnt.sv
// Saturating wait counter for the programming handshake. tc is raised during
// the TIMEOUT_CYCLES-th enabled cycle after a clear, so a sequence gets exactly
// TIMEOUT_CYCLES cycles of waiting before it is abandoned.
module dcm_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   // Count enabled cycles since the last clear; hold at the maximum, never wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tc = en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Programming sequencer for the clock manager: accepts set/step commands,
// issues one update strobe per change, waits for the manager to report the new
// selection and tracks the confirmed selection, busy/done and a sticky timeout.
module dcm_prog_ctrl
   import dcm_pkg::*;
#(
   parameter int                TIMEOUT_CYCLES = 1_000_000,
   parameter logic [PROG_W-1:0] RESET_PROG     = 3'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_op,
   input  logic [PROG_W-1:0] cmd_sel,
   output logic              cmd_ready,
   output logic              dcm_update,
   output logic [PROG_W-1:0] dcm_prog_in,
   input  logic [PROG_W-1:0] dcm_prog_out,
   output logic [PROG_W-1:0] cur_prog,
   output logic              busy,
   output logic              done,
   output logic              timeout
);

   state_t            state_q, state_d;
   logic              slot_vld_q;
   cmd_op_t           slot_op_q;
   logic [PROG_W-1:0] slot_sel_q;
   logic [PROG_W-1:0] tgt_q, tgt_d;
   logic [PROG_W-1:0] prog_in_q;
   logic [PROG_W-1:0] cur_prog_q;
   logic              timeout_q;

   logic              accept;
   logic              fill;
   logic              pop;
   logic              cnt_clr;
   logic              cnt_en;
   logic              cnt_tc;
   logic              wait_match;
   logic              wait_tmo;

   // NOPs are taken off the interface but otherwise ignored.
   assign accept = cmd_valid && !slot_vld_q && (cmd_op_t'(cmd_op) != OP_NOP);
   // Anything accepted while a sequence is running waits in the slot.
   assign fill   = accept && (state_q != ST_IDLE);

   assign cnt_clr    = (state_q == ST_ISSUE);
   assign cnt_en     = (state_q == ST_WAIT);
   // A match on the terminal cycle still counts as success.
   assign wait_match = (state_q == ST_WAIT) && (dcm_prog_out == tgt_q);
   assign wait_tmo   = (state_q == ST_WAIT) && !wait_match && cnt_tc;

   dcm_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk(clk),
      .rst(rst),
      .clr(cnt_clr),
      .en (cnt_en),
      .tc (cnt_tc)
   );

   // Next state, target resolution and slot pop.
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      pop     = 1'b0;
      case (state_q)
         ST_INIT: begin
            tgt_d   = RESET_PROG;
            state_d = ST_ISSUE;
         end
         ST_IDLE: begin
            if (slot_vld_q) begin
               pop     = 1'b1;
               tgt_d   = resolve_target(slot_op_q, slot_sel_q, cur_prog_q);
               state_d = (tgt_d == cur_prog_q) ? ST_DONE : ST_ISSUE;
            end else if (accept) begin
               tgt_d   = resolve_target(cmd_op_t'(cmd_op), cmd_sel, cur_prog_q);
               state_d = (tgt_d == cur_prog_q) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_match) begin
               state_d = ST_DONE;
            end else if (wait_tmo) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            // Pending step commands build on the sequence that just finished.
            if (slot_vld_q) begin
               pop     = 1'b1;
               tgt_d   = resolve_target(slot_op_q, slot_sel_q, tgt_q);
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Control state: FSM, slot occupancy, programmed/confirmed selection, error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_INIT;
         slot_vld_q <= 1'b0;
         prog_in_q  <= RESET_PROG;
         cur_prog_q <= RESET_PROG;
         timeout_q  <= 1'b0;
      end else begin
         state_q <= state_d;

         if (fill) begin
            slot_vld_q <= 1'b1;
         end else if (pop) begin
            slot_vld_q <= 1'b0;
         end

         // The manager sees the new selection together with the strobe.
         if (state_d == ST_ISSUE) begin
            prog_in_q <= tgt_d;
         end

         if (wait_match) begin
            cur_prog_q <= tgt_q;
         end else if (wait_tmo) begin
            cur_prog_q <= dcm_prog_out;
         end

         if (wait_tmo) begin
            timeout_q <= 1'b1;
         end else if (accept) begin
            timeout_q <= 1'b0;
         end
      end
   end

   // Slot payload and current target; only meaningful while qualified by state.
   always_ff @(posedge clk) begin
      if (fill) begin
         slot_op_q  <= cmd_op_t'(cmd_op);
         slot_sel_q <= cmd_sel;
      end
      tgt_q <= tgt_d;
   end

   assign cmd_ready   = !slot_vld_q;
   assign dcm_update  = (state_q == ST_ISSUE);
   assign dcm_prog_in = prog_in_q;
   assign cur_prog    = cur_prog_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Directed bench for dcm_prog_ctrl with a behavioural clock-manager model that
// reflects dcm_prog_in on dcm_prog_out a few cycles after each update strobe.
module tb_dcm_prog_ctrl;
   import dcm_pkg::*;

   localparam int TMO = 16;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic [1:0] cmd_op;
   logic [2:0] cmd_sel;
   logic       cmd_ready;
   logic       dcm_update;
   logic [2:0] dcm_prog_in;
   logic [2:0] dcm_prog_out = 3'd0;
   logic [2:0] cur_prog;
   logic       busy;
   logic       done;
   logic       timeout;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [2:0] exp_upd[$];
   logic [2:0] exp_done[$];
   int         upd_cyc[$];
   int         done_cyc[$];

   logic       stuck     = 1'b0;
   logic [2:0] stuck_val = 3'd0;
   logic [2:0] pend_val  = 3'd0;
   int         pend_cnt  = 0;
   int         n0;

   dcm_prog_ctrl #(
      .TIMEOUT_CYCLES(TMO),
      .RESET_PROG    (3'd0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_op      (cmd_op),
      .cmd_sel     (cmd_sel),
      .cmd_ready   (cmd_ready),
      .dcm_update  (dcm_update),
      .dcm_prog_in (dcm_prog_in),
      .dcm_prog_out(dcm_prog_out),
      .cur_prog    (cur_prog),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Clock-manager model: output follows the programmed value 3 cycles later,
   // or is pinned to stuck_val to emulate a manager that never locks.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (stuck) begin
         dcm_prog_out <= stuck_val;
      end else if (dcm_update) begin
         pend_val <= dcm_prog_in;
         pend_cnt <= 3;
      end else if (pend_cnt != 0) begin
         pend_cnt <= pend_cnt - 1;
         if (pend_cnt == 1) dcm_prog_out <= pend_val;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Scoreboard: every strobe and every done pulse is matched to an expectation.
   always @(negedge clk) begin
      if (dcm_update === 1'b1) begin
         upd_cyc.push_back(cyc);
         if (exp_upd.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL upd_unexpected observed=%0d expected=none", dcm_prog_in);
         end else begin
            chk("upd_prog_in", 32'(dcm_prog_in), 32'(exp_upd.pop_front()));
         end
      end
      if (done === 1'b1) begin
         done_cyc.push_back(cyc);
         if (exp_done.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL done_unexpected observed=%0d expected=none", cur_prog);
         end else begin
            chk("done_cur_prog", 32'(cur_prog), 32'(exp_done.pop_front()));
         end
      end
   end

   // Present a command and hold it until the DUT takes it; returns 1 ns after
   // the accepting edge.
   task automatic send(input logic [1:0] op, input logic [2:0] sel, input int budget);
      logic r;
      logic ok;
      ok = 1'b0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_sel   = sel;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         r = cmd_ready;
         @(posedge clk);
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cmd_sel   = 3'd0;
      chk("send_accepted", 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input int n, input int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (done_cyc.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_done", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_idle", 32'(ok), 32'd1);
   endtask

   initial begin
      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cmd_sel   = 3'd0;

      // Reset state
      @(posedge clk);
      #1;
      chk("rst_busy",      32'(busy),        32'd1);
      chk("rst_update",    32'(dcm_update),  32'd0);
      chk("rst_done",      32'(done),        32'd0);
      chk("rst_timeout",   32'(timeout),     32'd0);
      chk("rst_ready",     32'(cmd_ready),   32'd1);
      chk("rst_cur_prog",  32'(cur_prog),    32'd0);
      chk("rst_prog_in",   32'(dcm_prog_in), 32'd0);

      // Release: INIT programs selection 0 once
      exp_upd.push_back(3'd0);
      exp_done.push_back(3'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_done(1, 50);
      @(negedge clk);
      chk("init_busy_low", 32'(busy),           32'd0);
      chk("init_cur_prog", 32'(cur_prog),       32'd0);
      chk("init_n_upd",    32'(upd_cyc.size()), 32'd1);

      // SET 5, SLOWER while busy -> 6, third command held until the slot pops
      exp_upd.push_back(3'd5);  exp_done.push_back(3'd5);
      exp_upd.push_back(3'd6);  exp_done.push_back(3'd6);
      exp_upd.push_back(3'd3);  exp_done.push_back(3'd3);
      send(OP_SET, 3'd5, 20);
      @(negedge clk);
      chk("set5_update_next", 32'(dcm_update),  32'd1);
      chk("set5_prog_in",     32'(dcm_prog_in), 32'd5);
      send(OP_SLOWER, 3'd0, 20);
      chk("slot_full_ready", 32'(cmd_ready), 32'd0);
      send(OP_SET, 3'd3, 100);
      chk("third_after_pop", 32'(done_cyc.size()), 32'd2);
      chk("slot_refill_ready", 32'(cmd_ready), 32'd0);
      wait_done(4, 100);
      chk("b2b_gap_6", 32'(upd_cyc[2]), 32'(done_cyc[1] + 1));
      chk("b2b_gap_3", 32'(upd_cyc[3]), 32'(done_cyc[2] + 1));
      wait_idle(20);
      chk("seq_cur_prog", 32'(cur_prog), 32'd3);

      // Saturation at 7
      exp_upd.push_back(3'd7);
      exp_done.push_back(3'd7);
      send(OP_SET, 3'd7, 20);
      wait_done(5, 100);
      wait_idle(20);
      n0 = upd_cyc.size();
      exp_done.push_back(3'd7);
      send(OP_SLOWER, 3'd0, 20);
      @(negedge clk);
      chk("sat_hi_done", 32'(done), 32'd1);
      wait_idle(20);
      chk("sat_hi_no_upd",   32'(upd_cyc.size()), 32'(n0));
      chk("sat_hi_cur_prog", 32'(cur_prog),       32'd7);

      // Saturation at 0
      exp_upd.push_back(3'd0);
      exp_done.push_back(3'd0);
      send(OP_SET, 3'd0, 20);
      wait_done(7, 100);
      wait_idle(20);
      n0 = upd_cyc.size();
      exp_done.push_back(3'd0);
      send(OP_FASTER, 3'd0, 20);
      @(negedge clk);
      chk("sat_lo_done", 32'(done), 32'd1);
      wait_idle(20);
      chk("sat_lo_no_upd",   32'(upd_cyc.size()), 32'(n0));
      chk("sat_lo_cur_prog", 32'(cur_prog),       32'd0);

      // Timeout: manager stuck at 2, SET 4
      stuck_val = 3'd2;
      stuck     = 1'b1;
      exp_upd.push_back(3'd4);
      send(OP_SET, 3'd4, 20);
      repeat (17) @(negedge clk);
      chk("tmo_not_yet", 32'(timeout), 32'd0);
      chk("tmo_busy",    32'(busy),    32'd1);
      @(negedge clk);
      chk("tmo_set",      32'(timeout),  32'd1);
      chk("tmo_cur_prog", 32'(cur_prog), 32'd2);
      chk("tmo_idle",     32'(busy),     32'd0);
      stuck = 1'b0;
      exp_upd.push_back(3'd1);
      exp_done.push_back(3'd1);
      send(OP_SET, 3'd1, 20);
      chk("tmo_cleared", 32'(timeout), 32'd0);
      wait_done(9, 100);
      wait_idle(20);
      chk("post_tmo_cur_prog", 32'(cur_prog), 32'd1);

      // Asynchronous reset during WAIT with a command pending in the slot
      exp_upd.push_back(3'd6);
      send(OP_SET, 3'd6, 20);
      send(OP_SLOWER, 3'd0, 20);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_update",   32'(dcm_update),  32'd0);
      chk("arst_busy",     32'(busy),        32'd1);
      chk("arst_done",     32'(done),        32'd0);
      chk("arst_ready",    32'(cmd_ready),   32'd1);
      chk("arst_cur_prog", 32'(cur_prog),    32'd0);
      chk("arst_prog_in",  32'(dcm_prog_in), 32'd0);
      chk("arst_timeout",  32'(timeout),     32'd0);
      exp_upd.push_back(3'd0);
      exp_done.push_back(3'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_done(10, 100);
      wait_idle(20);
      chk("rearm_cur_prog", 32'(cur_prog), 32'd0);
      n0 = upd_cyc.size();
      repeat (5) @(negedge clk);
      chk("slot_flushed", 32'(upd_cyc.size()), 32'(n0));
      chk("rearm_idle",   32'(busy),           32'd0);

      chk("exp_upd_drained",  32'(exp_upd.size()),  32'd0);
      chk("exp_done_drained", 32'(exp_done.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
